// File: rtl/mac_pkg.sv
// Shared definitions for the MAC forwarding lookup: header/forward word layout, widths, FSM states.
// Aging is compiled in with `define MAC_FWD_AGING_EN.
package mac_pkg;

  localparam int MAC_W     = 48;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int GROUP_BIT = 40;

  localparam int HDR_W    = 114;
  localparam int DST_HI   = 113;
  localparam int DST_LO   = 66;
  localparam int SRC_HI   = 65;
  localparam int SRC_LO   = 18;
  localparam int ETYPE_HI = 17;
  localparam int ETYPE_LO = 2;
  localparam int PORT_HI  = 1;
  localparam int PORT_LO  = 0;

  // Forward word: {ingress port, egress mask}
  localparam int FWD_W = PORT_W + NUM_PORTS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LEARN  = 2'd2,
    S_EMIT   = 2'd3
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
    port_onehot = NUM_PORTS'(1) << port;
  endfunction

  function automatic logic [NUM_PORTS-1:0] flood_mask(input logic [PORT_W-1:0] in_port);
    flood_mask = {NUM_PORTS{1'b1}} & ~port_onehot(in_port);
  endfunction

endpackage

// File: rtl/mac_fwd_lookup_if.sv
// Header-FIFO / forward-FIFO bundle between the lookup engine (slave) and its FIFOs (master).
// Handshake: the header FIFO is first-word-fall-through; h_fifo_rden is a one-cycle pop issued only
// while h_fifo_empty is 0. f_fifo_wren is a one-cycle push issued only while f_fifo_full is 0, and
// f_fifo_din is held from that push until the next decision. rden and wren never share a cycle.
interface mac_fwd_if;
  import mac_pkg::*;

  logic [HDR_W-1:0] h_fifo_dout;
  logic             h_fifo_empty;
  logic             h_fifo_rden;
  logic [FWD_W-1:0] f_fifo_din;
  logic             f_fifo_full;
  logic             f_fifo_wren;

  modport master (
    output h_fifo_dout, h_fifo_empty, f_fifo_full,
    input  h_fifo_rden, f_fifo_din, f_fifo_wren
  );

  modport slave (
    input  h_fifo_dout, h_fifo_empty, f_fifo_full,
    output h_fifo_rden, f_fifo_din, f_fifo_wren
  );
endinterface

// File: rtl/mac_table.sv
// MAC table register array: combinational read by index, one write port, and an aging sweep.
// Hit flags and the sweep exist only when MAC_FWD_AGING_EN is defined.
module mac_table
  import mac_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [MAC_W-1:0]  rd_mac_o,
  output logic [PORT_W-1:0] rd_port_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [MAC_W-1:0]  wr_mac_i,
  input  logic [PORT_W-1:0] wr_port_i,
  input  logic              sweep_i
);

  logic [DEPTH-1:0]  valid_q;
  logic [MAC_W-1:0]  mac_q  [DEPTH];
  logic [PORT_W-1:0] port_q [DEPTH];

`ifdef MAC_FWD_AGING_EN
  logic [DEPTH-1:0] hit_q;

  // Sweep and write are never requested together: sweep only happens while the FSM idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      hit_q   <= '0;
    end else if (sweep_i) begin
      valid_q <= valid_q & hit_q;
      hit_q   <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      hit_q[wr_idx_i]   <= 1'b1;
    end
  end
`else
  logic sweep_unused;
  assign sweep_unused = sweep_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mac_q[wr_idx_i]  <= wr_mac_i;
      port_q[wr_idx_i] <= wr_port_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_mac_o   = mac_q[rd_idx_i];
  assign rd_port_o  = port_q[rd_idx_i];

endmodule

// File: rtl/mac_fwd_lookup.sv
// Learning L2 forwarding lookup: pops a header, scans the MAC table one entry per cycle, learns the
// source, and pushes {ingress, egress mask}. Optional aging sweep under `define MAC_FWD_AGING_EN.
module mac_fwd_lookup
  import mac_pkg::*;
#(
  parameter int          TABLE_DEPTH = 16,
  parameter logic [31:0] AGE_PERIOD  = 32'd125_000_000
) (
  input  logic     clk,
  input  logic     rst,
  mac_fwd_if.slave bus,
  output state_e   state_o
);

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rptr_q, rptr_d;
  logic [MAC_W-1:0]     dst_q, dst_d;
  logic [MAC_W-1:0]     src_q, src_d;
  logic [PORT_W-1:0]    in_port_q, in_port_d;
  logic                 dst_hit_q, dst_hit_d;
  logic [PORT_W-1:0]    dst_port_q, dst_port_d;
  logic                 src_hit_q, src_hit_d;
  logic [IDX_W-1:0]     src_idx_q, src_idx_d;
  logic                 free_found_q, free_found_d;
  logic [IDX_W-1:0]     free_idx_q, free_idx_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 rden_q, rden_d;
  logic                 wren_q, wren_d;
  logic [FWD_W-1:0]     din_q, din_d;

  logic                 rd_valid;
  logic [MAC_W-1:0]     rd_mac;
  logic [PORT_W-1:0]    rd_port;
  logic                 tbl_we;
  logic [IDX_W-1:0]     tbl_widx;
  logic                 sweep;
  logic                 sweep_req;
  logic [15:0]          ethertype_unused;

  assign ethertype_unused = bus.h_fifo_dout[ETYPE_HI:ETYPE_LO];

`ifdef MAC_FWD_AGING_EN
  logic [31:0] age_cnt_q;
  logic        sweep_pend_q;

  // A period ending in the same cycle as a sweep re-arms the pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_cnt_q    <= '0;
      sweep_pend_q <= 1'b0;
    end else begin
      if (sweep) sweep_pend_q <= 1'b0;
      if (age_cnt_q == AGE_PERIOD - 32'd1) begin
        age_cnt_q    <= '0;
        sweep_pend_q <= 1'b1;
      end else begin
        age_cnt_q <= age_cnt_q + 32'd1;
      end
    end
  end
  assign sweep_req = sweep_pend_q;
`else
  logic [31:0] age_period_unused;
  assign age_period_unused = AGE_PERIOD;
  assign sweep_req         = 1'b0;
`endif

  mac_table #(
    .DEPTH (TABLE_DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx_q),
    .rd_valid_o (rd_valid),
    .rd_mac_o   (rd_mac),
    .rd_port_o  (rd_port),
    .wr_en_i    (tbl_we),
    .wr_idx_i   (tbl_widx),
    .wr_mac_i   (src_q),
    .wr_port_i  (in_port_q),
    .sweep_i    (sweep)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rptr_d       = rptr_q;
    dst_d        = dst_q;
    src_d        = src_q;
    in_port_d    = in_port_q;
    dst_hit_d    = dst_hit_q;
    dst_port_d   = dst_port_q;
    src_hit_d    = src_hit_q;
    src_idx_d    = src_idx_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    mask_d       = mask_q;
    rden_d       = 1'b0;
    wren_d       = 1'b0;
    din_d        = din_q;
    tbl_we       = 1'b0;
    tbl_widx     = rptr_q;
    sweep        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sweep_req) begin
          sweep = 1'b1;
        end else if (!bus.h_fifo_empty) begin
          dst_d        = bus.h_fifo_dout[DST_HI:DST_LO];
          src_d        = bus.h_fifo_dout[SRC_HI:SRC_LO];
          in_port_d    = bus.h_fifo_dout[PORT_HI:PORT_LO];
          rden_d       = 1'b1;
          idx_d        = '0;
          dst_hit_d    = 1'b0;
          src_hit_d    = 1'b0;
          free_found_d = 1'b0;
          state_d      = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (rd_valid) begin
          if (!dst_hit_q && rd_mac == dst_q) begin
            dst_hit_d  = 1'b1;
            dst_port_d = rd_port;
          end
          if (!src_hit_q && rd_mac == src_q) begin
            src_hit_d = 1'b1;
            src_idx_d = idx_q;
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = S_LEARN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end

      S_LEARN: begin
        // Group source addresses are never learned.
        if (!src_q[GROUP_BIT]) begin
          tbl_we = 1'b1;
          if (src_hit_q) begin
            tbl_widx = src_idx_q;
          end else if (free_found_q) begin
            tbl_widx = free_idx_q;
          end else begin
            tbl_widx = rptr_q;
            rptr_d   = rptr_q + IDX_W'(1);
          end
        end
        if (dst_q[GROUP_BIT] || !dst_hit_q) mask_d = flood_mask(in_port_q);
        else if (dst_port_q == in_port_q)   mask_d = '0;
        else                                mask_d = port_onehot(dst_port_q);
        state_d = S_EMIT;
      end

      S_EMIT: begin
        if (!bus.f_fifo_full) begin
          wren_d  = 1'b1;
          din_d   = {in_port_q, mask_q};
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rptr_q       <= '0;
      dst_q        <= '0;
      src_q        <= '0;
      in_port_q    <= '0;
      dst_hit_q    <= 1'b0;
      dst_port_q   <= '0;
      src_hit_q    <= 1'b0;
      src_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      mask_q       <= '0;
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rptr_q       <= rptr_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      in_port_q    <= in_port_d;
      dst_hit_q    <= dst_hit_d;
      dst_port_q   <= dst_port_d;
      src_hit_q    <= src_hit_d;
      src_idx_q    <= src_idx_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      mask_q       <= mask_d;
      rden_q       <= rden_d;
      wren_q       <= wren_d;
      din_q        <= din_d;
    end
  end

  assign bus.h_fifo_rden = rden_q;
  assign bus.f_fifo_wren = wren_q;
  assign bus.f_fifo_din  = din_q;
  assign state_o         = state_q;

endmodule
